irq_eoi_initiator: RTL and testbench



---
 rtl/irq_eoi_pkg.sv | 19 +
 rtl/irq_eoi_initiator_if.sv | 30 +++
 rtl/irq_eoi_line.sv | 123 ++++++++++++
 rtl/sync_ff.sv | 25 ++
 rtl/irq_eoi_initiator.sv | 57 +++++
 tb/tb_irq_eoi_initiator.sv | 306 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/irq_eoi_pkg.sv
// Shared types and default parameters for the IRQ/EOI initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: line_state_e (per-line FSM encoding) and default parameter values.
package irq_eoi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2
    } line_state_e;

    localparam int N_LINES_DEF     = 16;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int PEND_W_DEF      = 4;
    localparam int TMO_W_DEF       = 16;

endpackage

// File: rtl/irq_eoi_initiator_if.sv
// IRQ/EOI pad bundle plus per-line status, shared by initiator and its user.
// Latency: n/a (wiring only).
// Backpressure: none; the pads use a req/ack handshake rather than valid/ready.
//
// master: the initiator (drives irq/pend/ovf/tmo/busy, samples evt/eoi).
// slave : event sources and the SOC-side pads (drive evt/eoi).
interface irq_eoi_initiator_if
    import irq_eoi_pkg::*;
#(
    parameter int N_LINES = N_LINES_DEF,
    parameter int PEND_W  = PEND_W_DEF
);
    logic [N_LINES-1:0]        evt;
    logic [N_LINES-1:0]        eoi;
    logic [N_LINES-1:0]        irq;
    logic [N_LINES*PEND_W-1:0] pend;
    logic [N_LINES-1:0]        ovf;
    logic [N_LINES-1:0]        tmo;
    logic                      busy;

    modport master (
        input  evt, eoi,
        output irq, pend, ovf, tmo, busy
    );

    modport slave (
        output evt, eoi,
        input  irq, pend, ovf, tmo, busy
    );
endinterface

// File: rtl/irq_eoi_line.sv
// One IRQ/EOI line: pending-event counter, req/ack FSM and ack timeout timer.
// Latency: evt in IDLE -> irq next edge; eoi_s rise -> irq low on the edge after (edge-detect flop).
// Backpressure: events queue in a saturating counter; an event arriving at saturation is dropped with an ovf pulse.
//
// Ports: clk, rstn, evt_i (event strobe), eoi_s_i (synchronised eoi), irq_o, pend_o,
//        ovf_o / tmo_o (one-cycle pulses), busy_o (FSM not idle or events queued).
module irq_eoi_line
    import irq_eoi_pkg::*;
#(
    parameter int PEND_W = PEND_W_DEF,
    parameter int TMO_W  = TMO_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              evt_i,
    input  logic              eoi_s_i,
    output logic              irq_o,
    output logic [PEND_W-1:0] pend_o,
    output logic              ovf_o,
    output logic              tmo_o,
    output logic              busy_o
);
    localparam int                SW        = PEND_W + 2;
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    // Timer value one short of all-ones: the edge that takes it to all-ones is the timeout edge.
    localparam logic [TMO_W-1:0]  TMO_LAST  = {{(TMO_W-1){1'b1}}, 1'b0};

    line_state_e       state_q, state_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [TMO_W-1:0]  tmr_q, tmr_d;
    logic              eoi_prev_q;
    logic              irq_q, irq_d;
    logic              ovf_q, ovf_d;
    logic              tmo_q, tmo_d;

    logic              consume;
    logic              timeout;
    logic              eoi_rise;
    logic              pend_nz;
    logic [SW-1:0]     pend_sum;

    assign eoi_rise = eoi_s_i & ~eoi_prev_q;
    assign pend_nz  = |pend_q;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            tmr_q      <= '0;
            eoi_prev_q <= 1'b0;
            irq_q      <= 1'b0;
            ovf_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            tmr_q      <= tmr_d;
            eoi_prev_q <= eoi_s_i;
            irq_q      <= irq_d;
            ovf_q      <= ovf_d;
            tmo_q      <= tmo_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        consume = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A lone evt with nothing queued is consumed straight away.
                if (pend_nz || evt_i) begin
                    state_d = ASSERT;
                    consume = 1'b1;
                end
            end
            ASSERT: begin
                // An ack landing on the timeout edge still counts as completion.
                if (eoi_rise) begin
                    state_d = RELEASE;
                end else if (tmr_q == TMO_LAST) begin
                    state_d = RELEASE;
                    timeout = 1'b1;
                end
            end
            RELEASE: begin
                if (!eoi_s_i) begin
                    if (pend_nz) begin
                        state_d = ASSERT;
                        consume = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        // consume never coincides with a timeout re-queue and never underflows.
        pend_sum = SW'(pend_q) + SW'(evt_i) + SW'(timeout) - SW'(consume);
        pend_d   = pend_sum[PEND_W-1:0];
        ovf_d    = 1'b0;
        if (pend_sum > SW'(PEND_MAX)) begin
            pend_d = PEND_MAX;
            ovf_d  = 1'b1;
        end
        tmo_d = timeout;
        irq_d = (state_d == ASSERT);
        // Timer restarts from 0 on every entry into ASSERT.
        tmr_d = ((state_q == ASSERT) && (state_d == ASSERT)) ? tmr_q + TMO_W'(1) : '0;
    end

    assign irq_o  = irq_q;
    assign pend_o = pend_q;
    assign ovf_o  = ovf_q;
    assign tmo_o  = tmo_q;
    assign busy_o = (state_q != IDLE) || pend_nz;
endmodule

// File: rtl/sync_ff.sv
// Multi-stage reset-to-0 synchroniser for one asynchronous bit.
// Latency: STAGES clock edges from d_i change to q_o.
// Backpressure: none.
//
// Ports: clk, rstn (async active-low), d_i (async input), q_o (synchronised output).
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/irq_eoi_initiator.sv
// Peripheral-side IRQ/EOI pad initiator: N_LINES independent req/ack lines with event queues.
// Latency: evt -> irq 1 cycle; eoi pad rise -> irq fall SYNC_STAGES+1 cycles.
// Backpressure: per-line saturating pending counter; drops flagged on ovf, missing acks on tmo.
//
// Ports: clk, rstn (async active-low), bus (irq_eoi_initiator_if.master: evt/eoi in,
//        irq/pend/ovf/tmo/busy out).
module irq_eoi_initiator
    import irq_eoi_pkg::*;
#(
    parameter int N_LINES     = N_LINES_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int PEND_W      = PEND_W_DEF,
    parameter int TMO_W       = TMO_W_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    irq_eoi_initiator_if.master   bus
);
    logic [N_LINES-1:0]        eoi_s;
    logic [N_LINES-1:0]        irq_v;
    logic [N_LINES*PEND_W-1:0] pend_v;
    logic [N_LINES-1:0]        ovf_v;
    logic [N_LINES-1:0]        tmo_v;
    logic [N_LINES-1:0]        busy_v;

    for (genvar i = 0; i < N_LINES; i++) begin : g_line
        sync_ff #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .rstn (rstn),
            .d_i  (bus.eoi[i]),
            .q_o  (eoi_s[i])
        );

        irq_eoi_line #(
            .PEND_W (PEND_W),
            .TMO_W  (TMO_W)
        ) u_line (
            .clk     (clk),
            .rstn    (rstn),
            .evt_i   (bus.evt[i]),
            .eoi_s_i (eoi_s[i]),
            .irq_o   (irq_v[i]),
            .pend_o  (pend_v[i*PEND_W +: PEND_W]),
            .ovf_o   (ovf_v[i]),
            .tmo_o   (tmo_v[i]),
            .busy_o  (busy_v[i])
        );
    end

    assign bus.irq  = irq_v;
    assign bus.pend = pend_v;
    assign bus.ovf  = ovf_v;
    assign bus.tmo  = tmo_v;
    assign bus.busy = |busy_v;
endmodule

// File: tb/tb_irq_eoi_initiator.sv
// Bench for irq_eoi_initiator: directed scenarios plus randomized traffic against a reference model.
// Latency: n/a.
// Backpressure: the bench acts as event source and as the SOC-side EOI responder.
module tb_irq_eoi_initiator;
    localparam int NL   = 16;
    localparam int SS   = 2;
    localparam int PW   = 4;
    localparam int TW   = 4;
    localparam int PMAX = (1 << PW) - 1;
    localparam int TLIM = (1 << TW) - 1;
    localparam int HD   = SS + 2;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    irq_eoi_initiator_if #(.N_LINES(NL), .PEND_W(PW)) bus ();

    irq_eoi_initiator #(
        .N_LINES     (NL),
        .SYNC_STAGES (SS),
        .PEND_W      (PW),
        .TMO_W       (TW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // ---------------- reference model ----------------
    // Per line: queued events, whether a request is out, whether we wait for the ack to drop,
    // the cycle the request went out, and the history of eoi values driven at each edge.
    int  m_pend [NL];
    bit  m_req  [NL];
    bit  m_rel  [NL];
    int  m_t0   [NL];
    bit  m_hist [NL][HD];
    bit  m_ovf  [NL];
    bit  m_tmo  [NL];
    int  m_acnt [NL];
    int  cyc;

    int  n_chk, n_pass;
    int  ovf_cnt [NL];
    int  tmo_cnt [NL];
    int  rise_cnt[NL];
    logic [NL-1:0] irq_prev;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_pend[i] = 0; m_req[i] = 0; m_rel[i] = 0; m_t0[i] = 0;
            m_ovf[i]  = 0; m_tmo[i] = 0;
            for (int j = 0; j < HD; j++) m_hist[i][j] = 0;
        end
    endtask

    task automatic model_step(input logic [NL-1:0] e, input logic [NL-1:0] q);
        cyc++;
        for (int i = 0; i < NL; i++) begin
            int  tot;
            bit  s, sp, con, rq;
            for (int j = HD - 1; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
            m_hist[i][0] = q[i];
            // The line sees the pad value from SS edges ago, and an edge against one edge earlier.
            s  = m_hist[i][SS];
            sp = m_hist[i][SS+1];
            con = 0; rq = 0; m_ovf[i] = 0; m_tmo[i] = 0;
            if (m_req[i]) begin
                if (s && !sp) begin
                    m_req[i] = 0; m_rel[i] = 1;
                end else if (cyc - m_t0[i] == TLIM) begin
                    m_req[i] = 0; m_rel[i] = 1; m_tmo[i] = 1; rq = 1;
                end
            end else if (m_rel[i]) begin
                if (!s) begin
                    m_rel[i] = 0;
                    if (m_pend[i] > 0) begin
                        con = 1; m_req[i] = 1; m_t0[i] = cyc; m_acnt[i]++;
                    end
                end
            end else if (m_pend[i] > 0 || e[i]) begin
                con = 1; m_req[i] = 1; m_t0[i] = cyc; m_acnt[i]++;
            end
            tot = m_pend[i] + int'(e[i]) + int'(rq) - int'(con);
            if (tot > PMAX) begin
                m_pend[i] = PMAX; m_ovf[i] = 1;
            end else begin
                m_pend[i] = tot;
            end
        end
    endtask

    task automatic compare_all();
        logic [NL-1:0]    x_irq, x_ovf, x_tmo;
        logic [NL*PW-1:0] x_pend;
        logic             x_busy;
        x_busy = 0;
        for (int i = 0; i < NL; i++) begin
            x_irq[i] = m_req[i];
            x_ovf[i] = m_ovf[i];
            x_tmo[i] = m_tmo[i];
            x_pend[i*PW +: PW] = PW'(m_pend[i]);
            if (m_req[i] || m_rel[i] || m_pend[i] > 0) x_busy = 1;
        end
        check("irq",  bus.irq,  x_irq);
        check("pend", bus.pend, x_pend);
        check("ovf",  bus.ovf,  x_ovf);
        check("tmo",  bus.tmo,  x_tmo);
        check("busy", bus.busy, x_busy);
    endtask

    task automatic tally();
        for (int i = 0; i < NL; i++) begin
            if (bus.ovf[i]) ovf_cnt[i]++;
            if (bus.tmo[i]) tmo_cnt[i]++;
            if (bus.irq[i] && !irq_prev[i]) rise_cnt[i]++;
        end
        irq_prev = bus.irq;
    endtask

    task automatic clear_tally();
        for (int i = 0; i < NL; i++) begin
            ovf_cnt[i] = 0; tmo_cnt[i] = 0; rise_cnt[i] = 0; m_acnt[i] = 0;
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance model, sample 1 time unit later.
    task automatic cycle(input logic [NL-1:0] e, input logic [NL-1:0] q);
        bus.evt = e;
        bus.eoi = q;
        @(posedge clk);
        model_step(e, q);
        #1;
        compare_all();
        tally();
    endtask

    function automatic logic [NL-1:0] onehot(input int i);
        logic [NL-1:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [PW-1:0] pend_of(input int i);
        return bus.pend[i*PW +: PW];
    endfunction

    // Randomized SOC responder: slow acks, early drops and occasional spurious acks.
    function automatic logic [NL-1:0] rnd_resp(input logic [NL-1:0] irq, input logic [NL-1:0] cur);
        logic [NL-1:0] r;
        for (int i = 0; i < NL; i++) begin
            if (irq[i] && !cur[i])      r[i] = ($urandom_range(0, 9) < 5);
            else if (irq[i] && cur[i])  r[i] = ($urandom_range(0, 3) != 0);
            else if (!irq[i] && cur[i]) r[i] = ($urandom_range(0, 1) == 0);
            else                        r[i] = ($urandom_range(0, 39) == 0);
        end
        return r;
    endfunction

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) cycle('0, bus.irq);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tot_rise, tot_exp;
        logic [NL-1:0] e, q;

        n_chk = 0; n_pass = 0; cyc = 0;
        irq_prev = '0;
        clear_tally();
        model_reset();
        rstn = 1'b0;
        bus.evt = '0;
        bus.eoi = '0;
        #2;
        check("rst_irq",  bus.irq,  0);
        check("rst_pend", bus.pend, 0);
        check("rst_ovf",  bus.ovf,  0);
        check("rst_tmo",  bus.tmo,  0);
        check("rst_busy", bus.busy, 0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Single event on line 3
        cycle(onehot(3), '0);
        check("single_irq_up", bus.irq[3], 1);
        cycle('0, onehot(3));
        cycle('0, onehot(3));
        check("single_irq_hold", bus.irq[3], 1);
        cycle('0, onehot(3));
        check("single_irq_down", bus.irq[3], 0);
        cycle('0, '0);
        cycle('0, '0);
        check("single_busy_hold", bus.busy, 1);
        cycle('0, '0);
        check("single_busy_clr", bus.busy, 0);

        // Queueing on line 0
        clear_tally();
        cycle(onehot(0), '0);
        repeat (5) cycle(onehot(0), '0);
        check("queue_pend5", pend_of(0), 5);
        rise_cnt[0] = 0;
        drain(150);
        check("queue_pend0", pend_of(0), 0);
        check("queue_rises", rise_cnt[0], 5);
        check("queue_no_ovf", ovf_cnt[0], 0);
        check("queue_idle", bus.busy, 0);

        // Saturation on line 7 (the line also times out once while flooded)
        clear_tally();
        repeat (18) cycle(onehot(7), '0);
        check("sat_pend", pend_of(7), PMAX);
        check("sat_ovf_cnt", ovf_cnt[7], 2);
        check("sat_tmo_cnt", tmo_cnt[7], 1);
        drain(300);
        check("sat_idle", bus.busy, 0);

        // Event coinciding with RELEASE->ASSERT consume on line 1
        clear_tally();
        repeat (3) cycle(onehot(1), '0);
        repeat (3) cycle('0, onehot(1));
        repeat (2) cycle('0, '0);
        check("simul_pend_pre", pend_of(1), 2);
        check("simul_irq_low", bus.irq[1], 0);
        cycle(onehot(1), '0);
        check("simul_pend", pend_of(1), 2);
        check("simul_irq_up", bus.irq[1], 1);
        drain(100);
        check("simul_idle", bus.busy, 0);

        // Timeout on line 5
        clear_tally();
        cycle(onehot(5), '0);
        repeat (14) cycle('0, '0);
        check("tmo_not_yet", bus.tmo[5], 0);
        check("tmo_irq_hold", bus.irq[5], 1);
        cycle('0, '0);
        check("tmo_pulse", bus.tmo[5], 1);
        check("tmo_irq_drop", bus.irq[5], 0);
        check("tmo_requeue", pend_of(5), 1);
        cycle('0, '0);
        check("tmo_reassert", bus.irq[5], 1);
        check("tmo_pend0", pend_of(5), 0);
        check("tmo_single", bus.tmo[5], 0);
        drain(100);
        check("tmo_idle", bus.busy, 0);

        // Reset in the middle of handshakes
        repeat (4) cycle('1, '0);
        check("rst_mid_irq", bus.irq, 16'hFFFF);
        check("rst_mid_pend", bus.pend, 64'h3333_3333_3333_3333);
        rstn = 1'b0;
        #1;
        check("rst_async_irq", bus.irq, 0);
        check("rst_async_pend", bus.pend, 0);
        check("rst_async_busy", bus.busy, 0);
        model_reset();
        bus.evt = '0;
        bus.eoi = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        irq_prev = '0;
        clear_tally();
        repeat (30) cycle('0, '0);
        tot_rise = 0;
        for (int i = 0; i < NL; i++) tot_rise += rise_cnt[i];
        check("rst_no_reissue", tot_rise, 0);

        // Randomized traffic
        clear_tally();
        q = '0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NL; i++) e[i] = ($urandom_range(0, 5) == 0);
            q = rnd_resp(bus.irq, q);
            cycle(e, q);
        end
        drain(600);
        check("rand_idle", bus.busy, 0);
        tot_rise = 0;
        tot_exp  = 0;
        for (int i = 0; i < NL; i++) begin
            tot_rise += rise_cnt[i];
            tot_exp  += m_acnt[i];
        end
        check("rand_rises", tot_rise, tot_exp);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
